// File: rtl/pcla_pkg.sv
// Shared helpers for the pipelined two-level CLA adder: group count,
// parameter legality check and the stage-1 control bundle.
package pcla_pkg;

    function automatic int ngroups(input int width, input int group);
        return width / group;
    endfunction

    // Legal when GROUP is 2..8 and WIDTH is a whole number of groups.
    function automatic bit width_legal(input int width, input int group);
        return (group >= 2) && (group <= 8) && (width >= group) && (width % group == 0);
    endfunction

    typedef struct packed {
        logic valid;
        logic c0;
    } stage_ctrl_t;

endpackage

// File: rtl/cla_group.sv
// One first-level CLA group: look-ahead bit carries plus group generate and
// propagate. Purely combinational.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] G,
    input  logic [GROUP-1:0] P,
    input  logic             cin,
    output logic [GROUP:1]   c,
    output logic             GG,
    output logic             PP
);

    // Each carry is a flat sum of products over the lower bits, not a chain.
    always_comb begin
        logic term;
        term = 1'b0;
        c    = '0;
        for (int i = 1; i <= GROUP; i++) begin
            term = cin;
            for (int m = 0; m < i; m++) term = term & P[m];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = G[j];
                for (int m = j + 1; m < i; m++) term = term & P[m];
                c[i] = c[i] | term;
            end
        end
        GG = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
            term = G[j];
            for (int m = j + 1; m < GROUP; m++) term = term & P[m];
            GG = GG | term;
        end
        PP = &P;
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined two-level CLA adder/subtractor with valid/ready flow control.
// Optional OVF output (signed overflow) enabled by defining PCLA_SIGNED_OVF_EN.
module pipelined_cla_adder
    import pcla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             CIN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH:0]   S
`ifdef PCLA_SIGNED_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int NG       = ngroups(WIDTH, GROUP);
    localparam bit WIDTH_OK = width_legal(WIDTH, GROUP);

    if (!WIDTH_OK) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP and GROUP in 2..8");
    end

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [NG-1:0]    gg;
        logic [NG-1:0]    pp;
        stage_ctrl_t      ctrl;
    } s1_t;

    s1_t            s1_q, s1_d;
    logic [WIDTH:0] s_q, s_d;
    logic           out_valid_q, out_valid_d;
    logic           s2_can_load;

    // Stage 1: effective operand and per-bit / per-group generate-propagate.
    logic [WIDTH-1:0]          y_eff, g1, p1;
    logic                      c0_in;
    logic [NG-1:0]             gg1, pp1;
    logic [NG-1:0][GROUP:1]    unused_s1_c;

    assign y_eff = SUB ? ~Y : Y;
    assign c0_in = SUB | CIN;
    assign g1    = X & y_eff;
    assign p1    = X ^ y_eff;

    for (genvar k = 0; k < NG; k++) begin : g_s1
        cla_group #(.GROUP(GROUP)) u_grp (
            .G   (g1[k*GROUP +: GROUP]),
            .P   (p1[k*GROUP +: GROUP]),
            .cin (1'b0),
            .c   (unused_s1_c[k]),
            .GG  (gg1[k]),
            .PP  (pp1[k])
        );
    end

    // Stage 2: second-level look-ahead over group carries.
    logic [NG-1:0] cg;

    always_comb begin
        logic term;
        term = 1'b0;
        cg   = '0;
        for (int k = 0; k < NG; k++) begin
            term = s1_q.ctrl.c0;
            for (int m = 0; m < k; m++) term = term & s1_q.pp[m];
            cg[k] = term;
            for (int j = 0; j < k; j++) begin
                term = s1_q.gg[j];
                for (int m = j + 1; m < k; m++) term = term & s1_q.pp[m];
                cg[k] = cg[k] | term;
            end
        end
    end

    // c2[i] is the carry into bit i; c2[WIDTH] is the carry out.
    logic [WIDTH:1]  c2;
    logic [NG-1:0]   unused_s2_gg, unused_s2_pp;
    logic [WIDTH:0]  sum2;

    for (genvar k = 0; k < NG; k++) begin : g_s2
        cla_group #(.GROUP(GROUP)) u_grp (
            .G   (s1_q.g[k*GROUP +: GROUP]),
            .P   (s1_q.p[k*GROUP +: GROUP]),
            .cin (cg[k]),
            .c   (c2[k*GROUP+1 +: GROUP]),
            .GG  (unused_s2_gg[k]),
            .PP  (unused_s2_pp[k])
        );
    end

    assign sum2 = {c2[WIDTH], s1_q.p ^ {c2[WIDTH-1:1], s1_q.ctrl.c0}};

    // Flow control: both stages advance whenever the output register can load.
    assign s2_can_load = !out_valid_q | OUT_READY;
    assign IN_READY    = !s1_q.ctrl.valid | s2_can_load;

`ifdef PCLA_SIGNED_OVF_EN
    logic ovf_q, ovf_d;
    assign OVF = ovf_q;
`endif

    always_comb begin
        s1_d        = s1_q;
        s_d         = s_q;
        out_valid_d = out_valid_q;
`ifdef PCLA_SIGNED_OVF_EN
        ovf_d       = ovf_q;
`endif
        if (IN_READY) begin
            s1_d.ctrl.valid = IN_VALID;
            if (IN_VALID) begin
                s1_d.g       = g1;
                s1_d.p       = p1;
                s1_d.gg      = gg1;
                s1_d.pp      = pp1;
                s1_d.ctrl.c0 = c0_in;
            end
        end
        if (s2_can_load) begin
            out_valid_d = s1_q.ctrl.valid;
            if (s1_q.ctrl.valid) begin
                s_d = sum2;
`ifdef PCLA_SIGNED_OVF_EN
                ovf_d = c2[WIDTH] ^ c2[WIDTH-1];
`endif
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q        <= '0;
            s_q         <= '0;
            out_valid_q <= 1'b0;
`ifdef PCLA_SIGNED_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            s1_q        <= s1_d;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
`ifdef PCLA_SIGNED_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign OUT_VALID = out_valid_q;
    assign S         = s_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: one 32/4 adder plus 12/4, 16/8 and 8/2 copies driven in
// lock-step, all checked against an arithmetic reference queue.
module tb_pipelined_cla_adder;

    logic        clk, rst;
    logic        in_valid, out_ready, cin, sub;
    logic [31:0] x, y;
    logic        in_ready, out_valid;
    logic [32:0] s;
    logic [12:0] s12;
    logic [16:0] s16;
    logic [8:0]  s8;
    logic        ov12, ov16, ov8;
    logic        unused_ir12, unused_ir16, unused_ir8;
`ifdef PCLA_SIGNED_OVF_EN
    logic        ovf, unused_ovf12, unused_ovf16, unused_ovf8;
`endif

    pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .X(x), .Y(y), .CIN(cin), .SUB(sub),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .S(s)
`ifdef PCLA_SIGNED_OVF_EN
        , .OVF(ovf)
`endif
    );

    pipelined_cla_adder #(.WIDTH(12), .GROUP(4)) dut12 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(unused_ir12),
        .X(x[11:0]), .Y(y[11:0]), .CIN(cin), .SUB(sub),
        .OUT_VALID(ov12), .OUT_READY(out_ready), .S(s12)
`ifdef PCLA_SIGNED_OVF_EN
        , .OVF(unused_ovf12)
`endif
    );

    pipelined_cla_adder #(.WIDTH(16), .GROUP(8)) dut16 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(unused_ir16),
        .X(x[15:0]), .Y(y[15:0]), .CIN(cin), .SUB(sub),
        .OUT_VALID(ov16), .OUT_READY(out_ready), .S(s16)
`ifdef PCLA_SIGNED_OVF_EN
        , .OVF(unused_ovf16)
`endif
    );

    pipelined_cla_adder #(.WIDTH(8), .GROUP(2)) dut8 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(unused_ir8),
        .X(x[7:0]), .Y(y[7:0]), .CIN(cin), .SUB(sub),
        .OUT_VALID(ov8), .OUT_READY(out_ready), .S(s8)
`ifdef PCLA_SIGNED_OVF_EN
        , .OVF(unused_ovf8)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [32:0] e32;
        logic [12:0] e12;
        logic [16:0] e16;
        logic [8:0]  e8;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference: plain integer arithmetic on w-bit operands; subtract as x + 2^w - y.
    function automatic logic [32:0] ref_add(input int w, input logic [31:0] xa, input logic [31:0] ya,
                                            input logic ci, input logic sb);
        longint unsigned mask, xs, ys, r;
        mask = (64'd1 << w) - 64'd1;
        xs   = {32'd0, xa} & mask;
        ys   = {32'd0, ya} & mask;
        r    = sb ? (xs + (mask + 64'd1) - ys) : (xs + ys + {63'd0, ci});
        return r[32:0];
    endfunction

    function automatic logic ref_ovf(input logic [31:0] xa, input logic [31:0] ya,
                                     input logic ci, input logic sb);
        longint v;
        v = sb ? (longint'($signed(xa)) - longint'($signed(ya)))
               : (longint'($signed(xa)) + longint'($signed(ya)) + longint'({31'd0, ci}));
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: check any output transfer, record any input transfer, advance.
    task automatic step(output bit acc_in);
        bit   acc_out;
        exp_t e;
        #1;
        acc_in  = in_valid && in_ready;
        acc_out = out_valid && out_ready;
        if (acc_out) begin
            chk("out_has_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("s32", 64'(s), 64'(e.e32));
                chk("s12", 64'(s12), 64'(e.e12));
                chk("s16", 64'(s16), 64'(e.e16));
                chk("s8", 64'(s8), 64'(e.e8));
                chk("narrow_valid", 64'({ov12, ov16, ov8}), 64'd7);
`ifdef PCLA_SIGNED_OVF_EN
                chk("ovf", 64'(ovf), 64'(e.ovf));
`endif
            end
        end
        if (acc_in) begin
            e.e32 = ref_add(32, x, y, cin, sub);
            e.e12 = 13'(ref_add(12, x, y, cin, sub));
            e.e16 = 17'(ref_add(16, x, y, cin, sub));
            e.e8  = 9'(ref_add(8, x, y, cin, sub));
            e.ovf = ref_ovf(x, y, cin, sub);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] xa, input logic [31:0] ya, input logic ci, input logic sb);
        bit acc;
        acc = 1'b0;
        x = xa; y = ya; cin = ci; sub = sb; in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(acc);
            if (acc) break;
        end
        chk("accept_within_bound", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 40 && q.size() > 0; i++) step(acc);
        chk("drained", 64'(q.size()), 64'd0);
        for (int i = 0; i < 3; i++) step(acc);
    endtask

    initial begin
        bit          acc;
        logic [31:0] pats [4];
        pats[0] = 32'h0000_0000; pats[1] = 32'hFFFF_FFFF;
        pats[2] = 32'hAAAA_AAAA; pats[3] = 32'h5555_5555;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; cin = 1'b0; sub = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_s", 64'(s), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 64'(in_ready), 64'd1);

        // Full-length propagate: latency and single-cycle valid pulse.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        chk("latency_not_early", 64'(out_valid), 64'd0);
        step(acc);
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("carry_chain_s", 64'(s), 64'h1_0000_0000);
        step(acc);
        chk("valid_pulse_ends", 64'(out_valid), 64'd0);

        // Subtraction with borrow and signed overflow.
        send(32'd5, 32'd7, 1'b0, 1'b1);
        send(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        send(32'd7, 32'd5, 1'b1, 1'b1);
        drain();

        // Back-pressure: two accepted, then stall with S held.
        out_ready = 1'b0;
        send(32'd1, 32'd1, 1'b1, 1'b0);
        send(32'd2, 32'd2, 1'b1, 1'b0);
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_s_first", 64'(s), 64'd3);
        x = 32'd3; y = 32'd3; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(acc);
            chk("bp_no_accept", 64'(acc), 64'd0);
            chk("bp_s_hold", 64'(s), 64'd3);
        end
        out_ready = 1'b1;
        send(32'd3, 32'd3, 1'b1, 1'b0);
        send(32'd4, 32'd4, 1'b1, 1'b0);
        drain();

        // Full throughput with random operands.
        for (int i = 0; i < 100; i++) begin
            x = $urandom; y = $urandom; cin = 1'($urandom_range(1));
            sub = 1'($urandom_range(1)); in_valid = 1'b1;
            step(acc);
            chk("thru_accept", 64'(acc), 64'd1);
            if (i >= 1) chk("thru_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        drain();

        // Corner patterns across all widths.
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int m = 0; m < 4; m++)
                    send(pats[a], pats[b], m[0], m[1]);
        drain();

        // Asynchronous reset with two results in flight.
        out_ready = 1'b0;
        send(32'd10, 32'd20, 1'b0, 1'b0);
        send(32'd30, 32'd40, 1'b0, 1'b0);
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_s", 64'(s), 64'd0);
        chk("async_rst_s8", 64'(s8), 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) step(acc);
        send(32'd3, 32'd4, 1'b0, 1'b0);
        step(acc);
        chk("post_rst_s", 64'(s), 64'd7);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
